// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one DATAWIDTH register among NREQ writers; SHARED_REG_ARBITER_LOCK_EN adds owner lock.
// Latency: one edge from sampled req to q/q_owner update with gnt and q_valid pulsing for the following cycle.
// Backpressure: none downstream; a requester holds req/d until it sees its gnt bit.
module shared_reg_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4
`ifdef SHARED_REG_ARBITER_LOCK_EN
    ,
    parameter int MAX_LOCK  = 8
`endif
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] d,
`ifdef SHARED_REG_ARBITER_LOCK_EN
    input  logic [NREQ-1:0]           lock,
`endif
    output logic [NREQ-1:0]           gnt,
    output logic [DATAWIDTH-1:0]      q,
    output logic                      q_valid,
    output logic [$clog2(NREQ)-1:0]   q_owner
);

    localparam int OW = $clog2(NREQ);

    logic [DATAWIDTH-1:0] d_word [NREQ];

    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [DATAWIDTH-1:0] q_q, q_d;
    logic                 q_valid_q, q_valid_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        last_q, last_d;

    logic                 rr_found;
    logic [OW-1:0]        rr_idx;
    logic [OW-1:0]        scan_idx;
    logic                 win_vld;
    logic [OW-1:0]        win_idx;

`ifdef SHARED_REG_ARBITER_LOCK_EN
    typedef enum logic {ARB, LOCKED} state_e;
    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 keep_lock;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign d_word[i] = d[i*DATAWIDTH +: DATAWIDTH];
    end

    // Search upward from the lane after the last winner, wrapping past NREQ-1.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = OW'((int'(last_q) + k) % NREQ);
            if (!rr_found && req[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        win_vld = rr_found;
        win_idx = rr_idx;
`ifdef SHARED_REG_ARBITER_LOCK_EN
        keep_lock = (state_q == LOCKED) && req[last_q] && lock[last_q]
                    && (cnt_q < 8'(MAX_LOCK));
        state_d   = ARB;
        cnt_d     = '0;
        if (keep_lock) begin
            win_vld = 1'b1;
            win_idx = last_q;
            state_d = LOCKED;
            cnt_d   = cnt_q + 8'd1;
        end else if (rr_found && lock[rr_idx]) begin
            // A fresh lock starts counting at the grant that acquired it.
            state_d = LOCKED;
            cnt_d   = 8'd1;
        end
`endif
        gnt_d     = '0;
        q_valid_d = 1'b0;
        q_d       = q_q;
        owner_d   = owner_q;
        last_d    = last_q;
        if (win_vld) begin
            gnt_d[win_idx] = 1'b1;
            q_valid_d      = 1'b1;
            q_d            = d_word[win_idx];
            owner_d        = win_idx;
            last_d         = win_idx;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            gnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            owner_q   <= '0;
            last_q    <= OW'(NREQ - 1);
`ifdef SHARED_REG_ARBITER_LOCK_EN
            state_q   <= ARB;
            cnt_q     <= '0;
`endif
        end else begin
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
`ifdef SHARED_REG_ARBITER_LOCK_EN
            state_q   <= state_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_owner = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: directed scenarios plus randomized requesters.
module tb_shared_reg_arbiter;
    localparam int DW = 8;
    localparam int N  = 4;
`ifdef SHARED_REG_ARBITER_LOCK_EN
    localparam int ML = 3;
`else
    localparam int ML = 1;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*DW-1:0] d = '0;
    logic [N-1:0]  lock_v = '0;
    logic [N-1:0]  gnt;
    logic [DW-1:0] q;
    logic          q_valid;
    logic [1:0]    q_owner;

    always #5 Clk = ~Clk;

    shared_reg_arbiter #(
        .DATAWIDTH(DW),
        .NREQ(N)
`ifdef SHARED_REG_ARBITER_LOCK_EN
        ,
        .MAX_LOCK(ML)
`endif
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .req(req),
        .d(d),
`ifdef SHARED_REG_ARBITER_LOCK_EN
        .lock(lock_v),
`endif
        .gnt(gnt),
        .q(q),
        .q_valid(q_valid),
        .q_owner(q_owner)
    );

    typedef struct {
        logic [N-1:0]  gnt;
        logic [DW-1:0] q;
        int            owner;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    int m_last = N - 1;
    bit m_locked = 1'b0;
    int m_cnt = 0;
    int mw = -1;
    logic [DW-1:0] dl [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: who wins at this edge given the sampled req/lock vectors.
    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] lk);
        exp_t e;
        mw = -1;
        if (m_locked && r[m_last] && lk[m_last] && m_cnt < ML) begin
            mw = m_last;
            m_cnt++;
        end else begin
            m_locked = 1'b0;
            m_cnt = 0;
            for (int k = 1; k <= N; k++) begin
                if (mw < 0 && r[(m_last + k) % N]) mw = (m_last + k) % N;
            end
            if (mw >= 0 && lk[mw]) begin
                m_locked = 1'b1;
                m_cnt = 1;
            end
        end
        if (mw >= 0) begin
            m_last  = mw;
            e.gnt   = '0;
            e.gnt[mw] = 1'b1;
            e.q     = d[mw*DW +: DW];
            e.owner = mw;
            sbq.push_back(e);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] lk);
        @(negedge Clk);
        req = r;
        lock_v = lk;
        for (int i = 0; i < N; i++)
            d[i*DW +: DW] = r[i] ? dl[i] : DW'($urandom);
        @(posedge Clk);
        model_edge(r, lk);
    endtask

    task automatic step_chk(input logic [N-1:0] r, input logic [N-1:0] lk,
                            input string name, input logic [N-1:0] exp_gnt);
        step(r, lk);
        #2;
        chk(name, gnt, exp_gnt);
    endtask

    // Monitor: every grant pulse must match the scoreboard entry pushed at that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_grant: got gnt=%b q_valid=1 expected no grant at %0t", gnt, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_gnt", gnt, e.gnt);
                    chk("sb_q", q, e.q);
                    chk("sb_owner", q_owner, e.owner);
                end
            end else begin
                if (sbq.size() != 0) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_grant: got q_valid=%b expected gnt=%b at %0t", q_valid, sbq[0].gnt, $time);
                    sbq.delete();
                end
                chk("idle_gnt", gnt, '0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    logic [N-1:0] pend;
    logic [N-1:0] lk_r;

    initial begin
        dl[0] = 8'h11; dl[1] = 8'h22; dl[2] = 8'h33; dl[3] = 8'h44;
        req = 4'b1111;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = dl[i];
        repeat (3) begin
            @(posedge Clk);
            #1;
            chk("rst_gnt", gnt, '0);
            chk("rst_q", q, '0);
            chk("rst_qv", q_valid, 0);
            chk("rst_owner", q_owner, 0);
        end
        @(negedge Clk);
        req = '0;
        Rst = 1'b1;

        step_chk(4'b1111, '0, "fair0", 4'b0001);
        step_chk(4'b1111, '0, "fair1", 4'b0010);
        step_chk(4'b1111, '0, "fair2", 4'b0100);
        step_chk(4'b1111, '0, "fair3", 4'b1000);
        step_chk(4'b1111, '0, "fair4", 4'b0001);

        dl[2] = 8'hA5;
        step_chk(4'b0100, '0, "single_gnt", 4'b0100);
        chk("single_q", q, 8'hA5);
        chk("single_owner", q_owner, 2);
        step(4'b0000, '0);
        #2;
        chk("hold_q", q, 8'hA5);
        chk("hold_qv", q_valid, 0);
        chk("hold_owner", q_owner, 2);

        step_chk(4'b1000, '0, "wrap_pre", 4'b1000);
        step_chk(4'b1001, '0, "wrap0", 4'b0001);
        step_chk(4'b1000, '0, "wrap3", 4'b1000);

        dl[2] = 8'h33;
        step_chk(4'b1111, '0, "pre_rst0", 4'b0001);
        step_chk(4'b1111, '0, "pre_rst1", 4'b0010);
        chk("pre_rst_q", q, 8'h22);
        #1;
        Rst = 1'b0;
        req = '0;
        #1;
        chk("async_q", q, '0);
        chk("async_gnt", gnt, '0);
        chk("async_qv", q_valid, 0);
        sbq.delete();
        m_last = N - 1;
        m_locked = 1'b0;
        m_cnt = 0;
        @(negedge Clk);
        Rst = 1'b1;
        step_chk(4'b1111, '0, "post_rst", 4'b0001);
        step_chk(4'b0010, '0, "post_rst1", 4'b0010);

`ifdef SHARED_REG_ARBITER_LOCK_EN
        step_chk(4'b0011, 4'b0001, "lock_a0", 4'b0001);
        step_chk(4'b0011, 4'b0001, "lock_a1", 4'b0001);
        step_chk(4'b0011, 4'b0001, "lock_a2", 4'b0001);
        step_chk(4'b0011, 4'b0001, "lock_max", 4'b0010);
        step_chk(4'b0011, 4'b0001, "lock_again", 4'b0001);
        step(4'b0000, '0);
        step_chk(4'b0110, 4'b0010, "lock_b0", 4'b0010);
        step_chk(4'b0110, 4'b0010, "lock_b1", 4'b0010);
        step_chk(4'b0110, 4'b0000, "lock_drop", 4'b0100);
`endif

        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    dl[i] = DW'($urandom);
                end
            end
`ifdef SHARED_REG_ARBITER_LOCK_EN
            lk_r = N'($urandom);
`else
            lk_r = '0;
`endif
            step(pend, lk_r);
            if (mw >= 0) pend[mw] = 1'b0;
        end

        step(4'b0000, '0);
        repeat (2) @(posedge Clk);
        #2;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
